// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC and one-hot fetch state encodings for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_DROP = 3'b100
  } fetch_state_e;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Small instruction buffer holding {pc, inst} entries; flush beats push, pop on empty is ignored.
module ifu_inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full,
  output logic [ENTRY_W-1:0] head
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // An empty buffer presents zeros so decode never sees stale or undefined entries.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC owner, single-outstanding icache requester and decode buffer.
// Optional performance counters are enabled with IFU_PERF_CNT_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  input  logic [INST_W-1:0] inst_data,
  input  logic              inst_valid,
  input  logic              redirect_ena,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              de_valid,
  output logic [INST_W-1:0] de_inst,
  output logic [ADDR_W-1:0] de_pc,
  input  logic              de_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_redirect_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NXT_W = CNT_W + 1;

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  pc_inc;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] fifo_head;
  logic               push;
  logic               pop_eff;
  logic [NXT_W-1:0]   count_next;
  logic               has_credit;

  assign pc_inc  = addr_q + 64'd4;
  assign pop_eff = de_ready && !fifo_empty;
  assign push    = (state == ST_REQ) && inst_valid && !redirect_ena && (!fifo_full || pop_eff);

  // Credit looks at occupancy after this cycle's push and pop settle.
  assign count_next = NXT_W'(fifo_count) + NXT_W'(push) - NXT_W'(pop_eff);
  assign has_credit = (count_next < NXT_W'(FIFO_DEPTH));

  ifu_inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (de_ready),
    .flush (redirect_ena),
    .din   ({addr_q, inst_data}),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (fifo_head)
  );

  // addr_q is the address on the icache bus; pc is where fetch resumes and may run ahead during DROP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (redirect_ena) begin
            pc <= redirect_pc;
          end else if (has_credit) begin
            state  <= ST_REQ;
            addr_q <= pc;
          end
        end
        ST_REQ: begin
          if (redirect_ena) begin
            pc    <= redirect_pc;
            state <= inst_valid ? ST_IDLE : ST_DROP;
          end else if (inst_valid) begin
            pc     <= pc_inc;
            addr_q <= pc_inc;
            if (!has_credit) state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (redirect_ena) pc <= redirect_pc;
          if (inst_valid)   state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign inst_ready = (state == ST_REQ) || (state == ST_DROP);
  assign inst_addr  = addr_q;
  assign de_valid   = !fifo_empty;
  assign de_pc      = fifo_head[ENTRY_W-1:INST_W];
  assign de_inst    = fifo_head[INST_W-1:0];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (redirect_ena && (perf_redirect_cnt != '1))
        perf_redirect_cnt <= perf_redirect_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; every icache response is driven cycle by cycle.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        redirect_ena;
  logic [63:0] redirect_pc;
  logic        de_valid;
  logic [31:0] de_inst;
  logic [63:0] de_pc;
  logic        de_ready;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_redirect_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] NO_PC  = 64'h0;
  localparam logic [31:0] W0 = 32'h1111_0001, W1 = 32'h2222_0002, W2 = 32'h3333_0003;
  localparam logic [31:0] W3 = 32'h4444_0004, W4 = 32'h5555_0005, W5 = 32'h6666_0006;
  localparam logic [31:0] W6 = 32'h7777_0007, W7 = 32'h8888_0008, JUNK = 32'hDEAD_BEEF;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr    (inst_addr),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .inst_valid   (inst_valid),
    .redirect_ena (redirect_ena),
    .redirect_pc  (redirect_pc),
    .de_valid     (de_valid),
    .de_inst      (de_inst),
    .de_pc        (de_pc),
    .de_ready     (de_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1ns after the edge they were captured on.
  task automatic applyStimulus(input logic iv, input logic [31:0] id, input logic re,
                               input logic [63:0] rp, input logic dr);
    inst_valid   = iv;
    inst_data    = id;
    redirect_ena = re;
    redirect_pc  = rp;
    de_ready     = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_valid = 1'b0; inst_data = '0; redirect_ena = 1'b0; redirect_pc = '0; de_ready = 1'b0;

    applyStimulus(0, '0, 0, NO_PC, 1);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("rst_inst_ready", 64'(inst_ready), 64'd0);
    checkOutput("rst_inst_addr", inst_addr, RST_PC);
    checkOutput("rst_de_valid", 64'(de_valid), 64'd0);
    checkOutput("rst_de_inst", 64'(de_inst), 64'd0);
    checkOutput("rst_de_pc", de_pc, 64'd0);

    // Sequential fetch, icache answers two cycles after the request appears
    rst = 1'b0;
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("first_req_ready", 64'(inst_ready), 64'd1);
    checkOutput("first_req_addr", inst_addr, 64'h8000_0000);
    applyStimulus(0, '0, 0, NO_PC, 1);
    applyStimulus(1, W0, 0, NO_PC, 1);
    checkOutput("w0_de_valid", 64'(de_valid), 64'd1);
    checkOutput("w0_de_pc", de_pc, 64'h8000_0000);
    checkOutput("w0_de_inst", 64'(de_inst), 64'(W0));
    checkOutput("w0_next_addr", inst_addr, 64'h8000_0004);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("w0_popped", 64'(de_valid), 64'd0);
    applyStimulus(1, W1, 0, NO_PC, 1);
    checkOutput("w1_de_pc", de_pc, 64'h8000_0004);
    checkOutput("w1_de_inst", 64'(de_inst), 64'(W1));
    checkOutput("w1_next_addr", inst_addr, 64'h8000_0008);
    applyStimulus(0, '0, 0, NO_PC, 1);
    applyStimulus(1, W2, 0, NO_PC, 1);
    checkOutput("w2_de_pc", de_pc, 64'h8000_0008);
    checkOutput("w2_de_inst", 64'(de_inst), 64'(W2));
    checkOutput("w2_next_addr", inst_addr, 64'h8000_000C);
    applyStimulus(0, '0, 0, NO_PC, 1);

    // Backpressure: two entries fill the buffer, fetch stalls until one is popped
    applyStimulus(1, W3, 0, NO_PC, 0);
    checkOutput("bp_one_ready", 64'(inst_ready), 64'd1);
    checkOutput("bp_one_addr", inst_addr, 64'h8000_0010);
    applyStimulus(1, W4, 0, NO_PC, 0);
    checkOutput("bp_full_ready", 64'(inst_ready), 64'd0);
    checkOutput("bp_full_de_pc", de_pc, 64'h8000_000C);
    applyStimulus(1, JUNK, 0, NO_PC, 0);
    checkOutput("bp_idle_ready", 64'(inst_ready), 64'd0);
    checkOutput("bp_idle_valid_ignored", 64'(de_inst), 64'(W3));
    applyStimulus(0, '0, 0, NO_PC, 0);
    checkOutput("bp_still_idle", 64'(inst_ready), 64'd0);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("bp_resume_ready", 64'(inst_ready), 64'd1);
    checkOutput("bp_resume_addr", inst_addr, 64'h8000_0014);
    checkOutput("bp_head_pc", de_pc, 64'h8000_0010);
    checkOutput("bp_head_inst", 64'(de_inst), 64'(W4));
    applyStimulus(0, '0, 0, NO_PC, 1);
    applyStimulus(1, W5, 0, NO_PC, 0);
    checkOutput("w5_de_pc", de_pc, 64'h8000_0014);

    // Redirect with the response three cycles away
    applyStimulus(0, '0, 1, 64'h8000_0100, 0);
    checkOutput("drop_ready", 64'(inst_ready), 64'd1);
    checkOutput("drop_addr_held", inst_addr, 64'h8000_0018);
    checkOutput("drop_flushed", 64'(de_valid), 64'd0);
    applyStimulus(0, '0, 0, NO_PC, 1);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("drop_wait_addr", inst_addr, 64'h8000_0018);
    applyStimulus(1, JUNK, 0, NO_PC, 1);
    checkOutput("drop_done_ready", 64'(inst_ready), 64'd0);
    checkOutput("drop_discarded", 64'(de_valid), 64'd0);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("redir_req_ready", 64'(inst_ready), 64'd1);
    checkOutput("redir_req_addr", inst_addr, 64'h8000_0100);

    // Redirect coincident with the response
    applyStimulus(1, JUNK, 1, 64'h8000_0300, 1);
    checkOutput("coinc_ready", 64'(inst_ready), 64'd0);
    checkOutput("coinc_not_pushed", 64'(de_valid), 64'd0);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("coinc_req_addr", inst_addr, 64'h8000_0300);

    // Two redirects while dropping; the last one wins
    applyStimulus(0, '0, 1, 64'h8000_0100, 1);
    applyStimulus(0, '0, 1, 64'h8000_0200, 1);
    checkOutput("dbl_drop_ready", 64'(inst_ready), 64'd1);
    checkOutput("dbl_drop_addr", inst_addr, 64'h8000_0300);
    applyStimulus(1, JUNK, 0, NO_PC, 1);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("dbl_req_addr", inst_addr, 64'h8000_0200);
    applyStimulus(1, W6, 0, NO_PC, 0);
    checkOutput("w6_de_pc", de_pc, 64'h8000_0200);
    checkOutput("w6_de_inst", 64'(de_inst), 64'(W6));
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetch", perf_fetch_cnt, 64'd7);
    checkOutput("perf_redirect", perf_redirect_cnt, 64'd4);
`endif

    // Reset while a request is outstanding
    rst = 1'b1;
    applyStimulus(0, '0, 0, NO_PC, 0);
    checkOutput("mid_rst_ready", 64'(inst_ready), 64'd0);
    checkOutput("mid_rst_addr", inst_addr, RST_PC);
    checkOutput("mid_rst_de_valid", 64'(de_valid), 64'd0);
    checkOutput("mid_rst_de_inst", 64'(de_inst), 64'd0);
    checkOutput("mid_rst_de_pc", de_pc, 64'd0);
`ifdef IFU_PERF_CNT_EN
    checkOutput("mid_rst_perf_fetch", perf_fetch_cnt, 64'd0);
    checkOutput("mid_rst_perf_redirect", perf_redirect_cnt, 64'd0);
`endif
    rst = 1'b0;
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("restart_ready", 64'(inst_ready), 64'd1);
    checkOutput("restart_addr", inst_addr, RST_PC);

    // PC increment wraps at the top of the 64-bit space
    applyStimulus(1, JUNK, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    applyStimulus(0, '0, 0, NO_PC, 1);
    checkOutput("wrap_req_addr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, W7, 0, NO_PC, 1);
    checkOutput("wrap_next_addr", inst_addr, 64'h0);
    checkOutput("wrap_de_pc", de_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_de_inst", 64'(de_inst), 64'(W7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
